kcr_prbg: RTL

KCR_PRBG -- requirements
Module: kcr_prbg

---
 rtl/kcr_prbg_if.sv | 23 ++
 rtl/kcr_prbg.sv | 112 +++++++++++
 2 files changed

// File: rtl/kcr_prbg_if.sv
// kcr_prbg_if: seed/control inputs and packed-word stream of the random bit generator
interface kcr_prbg_if #(
    parameter int W     = 8,
    parameter int OUT_W = 8,
    parameter int RW    = $clog2(W)
);
    logic              seed_load;
    logic [W-1:0]      x0, y0, p0, q0;
    logic [RW-1:0]     r1, r2, r3, r4;
    logic [W-1:0]      b3, b4;
    logic              mode, start, stop;
    logic [OUT_W-1:0]  word_out;
    logic              word_valid, word_ready, busy, seeded;
    logic [15:0]       word_cnt;
    modport master (
        output seed_load, x0, y0, p0, q0, r1, r2, r3, r4, b3, b4, mode, start, stop, word_ready,
        input  word_out, word_valid, busy, seeded, word_cnt
    );
    modport slave (
        input  seed_load, x0, y0, p0, q0, r1, r2, r3, r4, b3, b4, mode, start, stop, word_ready,
        output word_out, word_valid, busy, seeded, word_cnt
    );
endinterface

// File: rtl/kcr_prbg.sv
// kcr_prbg: dual chained-LCG pseudo-random bit generator packing bits into handshaked words
module kcr_prbg #(
    parameter int W     = 8,
    parameter int OUT_W = 8,
    parameter int RW    = $clog2(W)
) (
    input logic       clk,
    input logic       rst_n,
    kcr_prbg_if.slave bus
);
    localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t           state, state_nx;
    logic [W-1:0]     x, y, p, q, b3, b4, pn, xn, qn, yn;
    logic [RW-1:0]    r1, r2, r3, r4;
    logic [OUT_W-1:0] acc, full, held, word_out;
    logic [CW-1:0]    cnt;
    logic [15:0]      word_cnt;
    logic             word_valid, seeded, z, done, stall;

    function automatic logic [W-1:0] f(input logic [RW-1:0] r, input logic [W-1:0] inc, input logic [W-1:0] s);
        return (s << r) + s + inc;
    endfunction

    assign bus.word_out   = word_out;
    assign bus.word_valid = word_valid;
    assign bus.seeded     = seeded;
    assign bus.word_cnt   = word_cnt;
    assign bus.busy       = state != IDLE;

    // next LCG values, extracted bit and next FSM state for the current cycle
    always_comb begin
        pn       = f(r3, b3, p);
        xn       = f(r1, pn, x);
        qn       = f(r4, b4, q);
        yn       = f(r2, qn, y);
        z        = bus.mode ? xn[W-1] ^ yn[W-1] : xn > yn;
        full     = acc | (OUT_W'(z) << cnt);
        done     = cnt == CW'(OUT_W - 1);
        stall    = word_valid && !bus.word_ready;
        state_nx = state;
        case (state)
            IDLE:    state_nx = (bus.start && (seeded || bus.seed_load)) ? RUN : IDLE;
            RUN:     state_nx = bus.stop ? IDLE : (done && stall) ? HOLD : RUN;
            HOLD:    state_nx = bus.stop ? IDLE : bus.word_ready ? RUN : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // seeds, LCG stepping, bit packing and output word handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {x, y, p, q, b3, b4}   <= '0;
            {r1, r2, r3, r4}       <= '0;
            {acc, held, word_out}  <= '0;
            cnt                    <= '0;
            word_cnt               <= '0;
            word_valid             <= 1'b0;
            seeded                 <= 1'b0;
        end else begin
            if (word_valid && bus.word_ready) begin
                word_valid <= 1'b0;
                word_cnt   <= word_cnt + 16'd1;
            end
            if (state == IDLE && bus.seed_load) begin
                x      <= bus.x0;
                y      <= bus.y0;
                p      <= bus.p0;
                q      <= bus.q0;
                r1     <= bus.r1;
                r2     <= bus.r2;
                r3     <= bus.r3;
                r4     <= bus.r4;
                b3     <= bus.b3;
                b4     <= bus.b4;
                seeded <= 1'b1;
            end
            if (state == RUN && !bus.stop) begin
                p <= pn;
                x <= xn;
                q <= qn;
                y <= yn;
                if (done) begin
                    acc <= '0;
                    cnt <= '0;
                    if (stall) held <= full;
                    else begin
                        word_out   <= full;
                        word_valid <= 1'b1;
                    end
                end else begin
                    acc <= full;
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == HOLD && !bus.stop && bus.word_ready) begin
                word_out   <= held;
                word_valid <= 1'b1;
            end
            if (state != IDLE && bus.stop) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end
endmodule
